// File: rtl/pkt_timestamp_inserter_pkg.sv
// Shared widths, stamp field placement and types for the
// receive-path timestamp inserter.
package pkt_timestamp_inserter_pkg;

  localparam int C_TDATA_WIDTH   = 256;
  localparam int C_TUSER_WIDTH   = 128;
  localparam int TIMESTAMP_WIDTH = 64;
  localparam int TS_POS          = 64;

  // Stamp field bounds inside tuser.
  localparam int TS_LSB = TS_POS;
  localparam int TS_MSB = TS_POS + TIMESTAMP_WIDTH - 1;

  typedef logic [TIMESTAMP_WIDTH-1:0] stamp_t;
  typedef logic [31:0]                pkt_cnt_t;

endpackage

// File: rtl/pkt_timestamp_inserter_if.sv
// AXI4-Stream bundle (tdata/tkeep/tuser/tlast/tvalid/tready).
// master drives the beat, slave returns tready.
interface pkt_timestamp_inserter_if #(
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tlast;
  logic            tvalid;
  logic            tready;

  modport master (
    output tdata, tkeep, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/pkt_timestamp_inserter_axis_skid_buffer_2.sv
// Two-entry registered skid FIFO: head feeds the output, tail
// absorbs one beat of backpressure. Ports: in_* push side, out_* pop side.
module axis_skid_buffer_2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         ready_q, valid_q;
  logic         push, pop;

  assign push = in_valid_i & ready_q;
  assign pop  = valid_q & out_ready_i;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
      end
      2'b01: begin
        cnt_d  = cnt_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        // Occupancy unchanged; new beat lands behind the survivor.
        if (cnt_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (cnt_d <= 2'd1);
      valid_q <= (cnt_d != 2'd0);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;

endmodule

// File: rtl/pkt_timestamp_inserter.sv
// Writes stamp_counter into tuser of each packet's first beat, then
// skid-buffers the stream. Ports: axi_aclk/axi_resetn, stamp_counter,
// ts_en, s_axis (slave), m_axis (master); stamped_pkts when
// PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN is defined.
module pkt_timestamp_inserter
  import pkt_timestamp_inserter_pkg::*;
#(
  parameter int C_TDATA_WIDTH   = pkt_timestamp_inserter_pkg::C_TDATA_WIDTH,
  parameter int C_TUSER_WIDTH   = pkt_timestamp_inserter_pkg::C_TUSER_WIDTH,
  parameter int TIMESTAMP_WIDTH = pkt_timestamp_inserter_pkg::TIMESTAMP_WIDTH,
  parameter int TS_POS          = pkt_timestamp_inserter_pkg::TS_LSB
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
  input  logic                       ts_en,
  pkt_timestamp_inserter_if.slave    s_axis,
  pkt_timestamp_inserter_if.master   m_axis
`ifdef PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN
  ,
  output pkt_cnt_t                   stamped_pkts
`endif
);

  localparam int KW = C_TDATA_WIDTH / 8;
  localparam int W  = C_TDATA_WIDTH + KW + C_TUSER_WIDTH + 1;

  logic                     sop_q, sop_d;
  logic                     accept;
  logic [C_TUSER_WIDTH-1:0] tuser_st;
  logic [W-1:0]             in_beat, out_beat;

  assign accept = s_axis.tvalid & s_axis.tready;
  assign sop_d  = accept ? s_axis.tlast : sop_q;

  // ts_en only matters on the first beat, so a mid-packet
  // toggle cannot split one packet's treatment.
  always_comb begin
    tuser_st = s_axis.tuser;
    if (sop_q & ts_en)
      tuser_st[TS_POS +: TIMESTAMP_WIDTH] = stamp_counter;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) sop_q <= 1'b1;
    else             sop_q <= sop_d;
  end

`ifdef PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN
  pkt_cnt_t cnt_q, cnt_d;

  assign cnt_d = (accept & sop_q & ts_en) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  assign stamped_pkts = cnt_q;
`endif

  assign in_beat = {s_axis.tlast, tuser_st,
                    s_axis.tkeep, s_axis.tdata};

  axis_skid_buffer_2 #(.W(W)) u_skid (
    .clk_i       (axi_aclk),
    .rst_ni      (axi_resetn),
    .in_data_i   (in_beat),
    .in_valid_i  (s_axis.tvalid),
    .in_ready_o  (s_axis.tready),
    .out_data_o  (out_beat),
    .out_valid_o (m_axis.tvalid),
    .out_ready_i (m_axis.tready)
  );

  assign {m_axis.tlast, m_axis.tuser,
          m_axis.tkeep, m_axis.tdata} = out_beat;

endmodule

// File: tb/tb_pkt_timestamp_inserter.sv
// Scoreboard bench for pkt_timestamp_inserter: directed packets
// followed by randomized traffic against a per-packet stamping model.
module tb_pkt_timestamp_inserter;
  import pkt_timestamp_inserter_pkg::*;

  localparam int DW = C_TDATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int UW = C_TUSER_WIDTH;
  localparam int TW = TIMESTAMP_WIDTH;
  localparam int BW = DW + KW + UW + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    int            cyc;
    bit            lat;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] stamp_counter = '0;
  logic          ts_en = 1'b0;

  pkt_timestamp_inserter_if #(.DW(DW), .UW(UW)) s_if ();
  pkt_timestamp_inserter_if #(.DW(DW), .UW(UW)) m_if ();

`ifdef PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN
  logic [31:0] stamped_pkts;
`endif

  pkt_timestamp_inserter dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .stamp_counter (stamp_counter),
    .ts_en         (ts_en),
    .s_axis        (s_if),
    .m_axis        (m_if)
`ifdef PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN
    ,
    .stamped_pkts  (stamped_pkts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    total = 0;
  int    bad = 0;
  beat_t q[$];
  bit    sop_m = 1'b1;
  bit    lat_on = 1'b0;
  bit    rnd_mode = 1'b0;
  int    nstamp = 0;
  bit    held = 1'b0;
  logic [BW-1:0] hv;

  task automatic check(input string nm,
                       input logic [511:0] act,
                       input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rnd_u();
    logic [UW-1:0] r;
    for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic nxt();
    @(negedge clk);
    stamp_counter = stamp_counter + 1'b1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) nxt();
  endtask

  // Offer one beat, hold it until taken, record what must come out.
  task automatic send(input bit last, input logic [UW-1:0] u);
    beat_t e;
    int    n;
    n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = rnd_d();
    s_if.tkeep  = KW'($urandom);
    s_if.tuser  = u;
    s_if.tlast  = last;
    while (s_if.tready !== 1'b1 && n < 64) begin
      nxt();
      n++;
    end
    if (n >= 64) begin
      check("s_ready_timeout", 0, 1);
      s_if.tvalid = 1'b0;
      return;
    end
    e.d = s_if.tdata;
    e.k = s_if.tkeep;
    e.u = u;
    if (sop_m && ts_en) begin
      e.u[TS_POS +: TW] = stamp_counter;
      nstamp++;
    end
    e.l   = last;
    e.cyc = cyc;
    e.lat = lat_on;
    q.push_back(e);
    sop_m = last;
    nxt();
  endtask

  // Output monitor: pops on every handshake, checks stall stability.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held)
          check("stall_stable",
                {m_if.tvalid, m_if.tlast, m_if.tuser,
                 m_if.tkeep, m_if.tdata},
                {1'b1, hv});
        held = 1'b0;
        if (m_if.tvalid === 1'b1) begin
          if (m_if.tready) begin
            if (q.size() == 0) begin
              check("unexpected_beat", 1, 0);
            end else begin
              e = q.pop_front();
              check("beat",
                    {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata},
                    {e.l, e.u, e.k, e.d});
              if (e.lat) check("latency", cyc, e.cyc + 1);
            end
          end else begin
            held = 1'b1;
            hv = {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata};
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_mode) m_if.tready = ($urandom % 4) != 0;
    end
  end

  initial begin
    logic [UW-1:0] u;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    #1;
    check("rst_m_valid", m_if.tvalid, 0);
    check("rst_s_ready", s_if.tready, 0);
    check("rst_m_data", {m_if.tuser, m_if.tdata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nxt();
    check("rel_s_ready", s_if.tready, 1);
    check("rel_m_valid", m_if.tvalid, 0);
    ts_en = 1'b1;

    // 3-beat stamped packet, then back-to-back single beats
    lat_on = 1'b1;
    stamp_counter = 64'h100;
    send(1'b0, rnd_u());
    send(1'b0, rnd_u());
    send(1'b1, rnd_u());
    idle(3);
    stamp_counter = 64'h200;
    repeat (4) send(1'b1, rnd_u());
    idle(3);
    lat_on = 1'b0;

    // Backpressure mid-packet
    send(1'b0, rnd_u());
    send(1'b0, rnd_u());
    m_if.tready = 1'b0;
    fork
      begin
        repeat (5) @(negedge clk);
        #1;
        check("bp_s_ready", s_if.tready, 0);
        check("bp_occupancy", q.size(), 2);
        m_if.tready = 1'b1;
      end
    join_none
    send(1'b0, rnd_u());
    send(1'b0, rnd_u());
    send(1'b0, rnd_u());
    send(1'b1, rnd_u());
    idle(4);

    // ts_en off at SOP, turned on mid-packet
    ts_en = 1'b0;
    u = rnd_u();
    u[TS_POS +: TW] = 64'hDEAD_BEEF;
    send(1'b0, u);
    ts_en = 1'b1;
    send(1'b0, rnd_u());
    send(1'b1, rnd_u());
    send(1'b1, rnd_u());
    idle(3);

    // Counter wrap
    stamp_counter = '1;
    send(1'b1, rnd_u());
    send(1'b1, rnd_u());
    idle(3);

    // Reset after beat1 of a 4-beat packet
    m_if.tready = 1'b0;
    send(1'b0, rnd_u());
    send(1'b0, rnd_u());
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    q.delete();
    sop_m = 1'b1;
    nstamp = 0;
    #1;
    check("mid_rst_m_valid", m_if.tvalid, 0);
    check("mid_rst_s_ready", s_if.tready, 0);
`ifdef PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN
    check("mid_rst_cnt", stamped_pkts, 0);
`endif
    nxt();
    nxt();
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    nxt();
    check("post_rst_s_ready", s_if.tready, 1);
    stamp_counter = 64'h5000;
    send(1'b0, rnd_u());
    send(1'b1, rnd_u());
`ifdef PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN
    check("post_rst_cnt", stamped_pkts, 1);
`endif
    idle(3);

    // Randomized traffic
    rnd_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 8 == 0) ts_en = 1'($urandom);
      if ($urandom % 50 == 0)
        stamp_counter = {$urandom, $urandom};
      if ($urandom % 10 < 7) send(($urandom % 3) == 0, rnd_u());
      else                   idle(1);
    end
    rnd_mode = 1'b0;
    idle(1);
    m_if.tready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) nxt();
    check("drain", q.size(), 0);
`ifdef PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN
    check("final_cnt", stamped_pkts, nstamp);
`endif
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_timestamp_inserter.md
Name: pkt_timestamp_inserter

Overview:
- Downstream consumer of the free-running 64-bit stamp counter.
- Sits in the receive AXI4-Stream path. Samples the counter value on the cycle each packet's first beat is accepted, and writes it into a fixed tuser field of that first beat.
- Full-throughput, fully registered pass-through, with a 2-entry skid buffer so backpressure never drops or reorders beats.

Parameters:
- C_TDATA_WIDTH, 256, AXI-Stream data width (bits).
- C_TUSER_WIDTH, 128, AXI-Stream tuser width (bits).
- TIMESTAMP_WIDTH, 64, stamp width; must equal the counter width.
- TS_POS, 64, LSB position of the stamp field in tuser; TS_POS+TIMESTAMP_WIDTH <= C_TUSER_WIDTH.

Ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  asynchronous active-low reset.
- stamp_counter  in  TIMESTAMP_WIDTH  free-running time value, same clock domain.
- ts_en  in  1  1 = stamp packets; 0 = pass tuser unchanged.
- s_axis_tdata  in  C_TDATA_WIDTH  input data.
- s_axis_tkeep  in  C_TDATA_WIDTH/8  byte enables.
- s_axis_tuser  in  C_TUSER_WIDTH  sideband.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata / tkeep / tuser / tlast  out  widths as above  output beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0; s_axis_tready=0 during reset, 1 on first cycle after release; both skid entries empty; SOP flag=1. Data outputs reset to 0.
- SOP tracking: flag sop is 1 after reset. Cleared on any accepted beat with tlast=0. Set on any accepted beat with tlast=1. A single-beat packet is both SOP and EOP.
- Stamp sample: on the cycle where s_axis_tvalid & s_axis_tready & sop & ts_en, the beat is written into the buffer with tuser[TS_POS +: TIMESTAMP_WIDTH] = stamp_counter of that same cycle. All other tuser bits pass unchanged.
- Non-SOP beats, and all beats when ts_en=0, pass tuser unmodified.
- ts_en is sampled per SOP beat only. Toggling ts_en mid-packet does not affect that packet.
- Latency: 1 cycle from slave accept to m_axis_tvalid when the buffer is empty and m_axis_tready=1.
- Skid buffer:
  - 2 entries, strict FIFO order.
  - s_axis_tready is registered: 1 when at most one entry will be occupied next cycle.
  - Simultaneous push and pop with 1 entry held keeps occupancy 1.
  - Push while full cannot occur (tready=0).
  - Pop when empty cannot occur (tvalid=0).
- AXI rules:
  - m_axis_tvalid, once high, stays high and output fields stay stable until m_axis_tready.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
- Throughput: 1 beat/cycle sustained with m_axis_tready=1.
- Counter wrap: the stamp is a raw copy; wrap from all-ones to 0 needs no special handling.
- Reset mid-packet: buffered beats are discarded and sop returns to 1. The next accepted beat is treated as SOP.

Optional Feature:
- Macro: PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN.
- When defined: adds output port stamped_pkts (32 bits). It increments by 1 on each stamped SOP accept, wraps at 2^32-1 to 0, and resets to 0.
- When undefined: the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds the default widths, TS_POS, the tuser field-offset constants, and the stamp type.
- One sub-module: axis_skid_buffer_2 (parameterised width; holds the 2-entry storage and the registered ready). The top wraps it with SOP tracking and the stamp mux.

Test Plan:
- Stamped packet: 3-beat packet, m_ready=1, stamp_counter=0x100 at SOP accept. Response: beat0 tuser[127:64]=0x100, beats1-2 tuser unchanged, output 1 cycle later.
- Single-beat packets back-to-back: with counter=0x200, four 1-beat packets. Response: stamps 0x200, 0x201, 0x202, 0x203 and no bubbles.
- Backpressure: hold m_ready=0 for 5 cycles mid-packet. Response: s_ready drops after 2 buffered beats, no beat lost or duplicated, and output is stable while stalled. The stamp equals the counter at SOP accept, not at output.
- ts_en=0: packet with input tuser=0xDEAD_BEEF in the stamp field. Response: field output unchanged. Then set ts_en=1 mid-packet. Response: that packet is still unstamped and the next packet is stamped.
- Wrap: counter=0xFFFF_FFFF_FFFF_FFFF at SOP. Response: stamp=all-ones. Next packet's stamp=0x0000_0000_0000_0000 (or later).
- Reset mid-packet: assert axi_resetn=0 after beat1 of 4. Response: m_valid=0 immediately. After release, the next accepted beat is stamped as SOP. With PKT_TIMESTAMP_INSERTER_STAMP_CNT_EN defined, stamped_pkts=0 after reset and equals 1 after that packet.
